mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the tiny16 controller's memory strobes. It latches addresses, performs writes and returns read data in response to `mem_addr_en`, `mem_in_en` and `mem_out_en`, with a configurable number of wait states. It sits on the shared 16-bit data bus beside the register file and ALU. It reports completion with `done`, reports readiness with `ready`, and flags protocol violations with `err`.

## Interface
- `ADDR_W`, default 8: word-address width; the array holds 2^ADDR_W words of 16 bits.
- `WAIT_STATES`, default 1: extra busy cycles per read or write; legal range 0..7.

Ports:
- `clk`  input  1  system clock; rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `bus_in`  input  16  current value on the shared data bus.
- `mem_addr_en`  input  1  latch `bus_in` into the address register (MAR).
- `mem_in_en`  input  1  write request; data is taken from `bus_in`.
- `mem_out_en`  input  1  read request.
- `out`  output  16  read data; 0 whenever `out_en`=0, so it can be OR-ed onto the bus.
- `out_en`  output  1  read data valid; one-cycle pulse.
- `ready`  output  1  idle and able to accept a strobe; decoded combinationally from the state.
- `done`  output  1  transaction complete; one-cycle pulse, high for both reads and writes.
- `err`  output  1  protocol error; one-cycle pulse.

## Operation
- **State machine:**
  - States are IDLE, RD, WR and DONE.
  - `ready` = (state==IDLE).
  - `done` = (state==DONE).
  - `out_en` = (state==DONE and the transaction was a read).
- **Address, IDLE with only `mem_addr_en`=1:**
  - `mar` ← `bus_in` at the edge.
  - State stays IDLE; no `done` pulse.
- **Write, IDLE with only `mem_in_en`=1:**
  - `wdata` ← `bus_in`; `cnt` ← WAIT_STATES; go to WR.
  - In WR: if `cnt`==0, write `mem[mar[ADDR_W-1:0]]` ← `wdata` and go to DONE; otherwise decrement `cnt`.
- **Read, IDLE with only `mem_out_en`=1:**
  - `cnt` ← WAIT_STATES; go to RD.
  - In RD: if `cnt`==0, `rdata` ← `mem[mar]` and go to DONE; otherwise decrement `cnt`.
- **DONE:** lasts one cycle, then IDLE. All strobes are ignored in DONE.
- **Handshake:**
  - The requester holds its strobe until it sees `done`, and drops it by the edge that ends DONE.
  - A strobe still high in the following IDLE cycle starts a new transaction.
- **Address wrap:** `mar` is 16 bits, but only `mar[ADDR_W-1:0]` indexes the array. Upper bits are ignored, so addresses alias modulo 2^ADDR_W.
- **Multiple strobes high in IDLE:** `err` pulses; no action; `mar` and memory are unchanged.
- **Owning strobe dropped in RD/WR:** abort to IDLE; no write occurs; `err` pulses; no `done`.
- **Non-owning strobe high in RD/WR:** `err` pulses; the strobe is ignored and the transaction continues.
- **Reset:**
  - State=IDLE; `mar`, `wdata`, `rdata`, `cnt` = 0.
  - `out`=0, `out_en`=0, `done`=0, `err`=0, `ready`=1.
  - Array contents are not reset.
  - Reset mid-transaction discards it; a pending write never lands.

## Timing
- A strobe sampled at edge n enters RD/WR for WAIT_STATES+1 cycles, with `ready`=0 throughout.
- The array write, or the `rdata` load, happens at edge n+WAIT_STATES+1.
- `done`, and for reads also `out_en` and `out`, are high during the cycle after edge n+WAIT_STATES+1.
- `ready` returns high after edge n+WAIT_STATES+2.
- Total occupancy is WAIT_STATES+2 cycles per read or write.
- An address latch takes one cycle, and back-to-back latches are allowed on every edge.
- `err` is registered: high in the cycle after the offending edge, for exactly one cycle.
- The array uses synchronous write and synchronous read. No combinational path exists from any input to `out`.

## Structure
- **Shared header `tiny16_defs.vh`** holds:
  - the state encodings (IDLE=0, RD=1, WR=2, DONE=3);
  - the word width of 16 bits;
  - the WAIT_STATES maximum of 7.
- **Sub-module `mem_array`:** single-port RAM, parameterised by ADDR_W. Ports: `clk`, `we`, `addr`, `wdata`, `rdata`, with registered read. It is instantiated once.
- **Top level** contains the FSM, `mar`, `wdata`, `cnt`, the error detection, and the `out` gating.

## Test plan
- **Write then read, WAIT_STATES=1:**
  - Stimulus: `mem_addr_en` with `bus_in`=0x0012; then `mem_in_en` with 0xBEEF, held; then `mem_out_en`, held.
  - Response: `ready`=0 for 2 cycles and `done` in the 3rd on both the write and the read. `out`=0xBEEF with `out_en`=1 for exactly one cycle.
- **Zero wait states, WAIT_STATES=0:**
  - Stimulus: read of a preloaded 0x1234, with the strobe sampled at edge n.
  - Response: `out_en`=1 and `out`=0x1234 only in the cycle after edge n+1. `out`=0 on every other cycle.
- **Address aliasing, ADDR_W=8:**
  - Stimulus: write 0xA5A5 to address 0x0105, then read address 0x0005.
  - Response: `out`=0xA5A5.
- **Conflicting strobes:**
  - Stimulus: `mem_in_en` and `mem_out_en` both high in IDLE.
  - Response: `err` pulses for 1 cycle; `ready` stays 1; no `done`; a later read shows the location unchanged.
- **Aborted write:**
  - Stimulus: location holds 0x0001; start a write of 0xFFFF and drop `mem_in_en` after 1 WR cycle, with WAIT_STATES=2.
  - Response: `err` pulses; state returns to IDLE; no `done`; a readback gives 0x0001.
- **Reset mid-read:**
  - Stimulus: assert `rst`=0 asynchronously during RD.
  - Response: `out`, `out_en`, `done` and `err` go to 0 immediately and `ready`=1. After release, a new read completes normally.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the tiny16 memory responder: state encoding,
// bus word width and wait-state limit.
package mem_responder_pkg;

    localparam int WORD_W    = 16;
    localparam int WAIT_MAX  = 7;
    localparam int CNT_W     = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // True when more than one strobe bit is set.
    function automatic logic multi_hot(input logic [2:0] s);
        return (s & (s - 3'd1)) != 3'd0;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word RAM with synchronous write and registered read.
// Read is read-before-write; contents are never reset.
module mem_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the tiny16 memory strobes: address latch,
// wait-stated reads and writes, and protocol error flagging.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready; accepts one strobe (address latch, write or read)
// ST_RD   | read in progress; counts down wait states, owns mem_out_en
// ST_WR   | write in progress; counts down wait states, owns mem_in_en
// ST_DONE | one-cycle completion; done (and out_en for reads) high
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] bus_in,
    input  logic              mem_addr_en,
    input  logic              mem_in_en,
    input  logic              mem_out_en,
    output logic [WORD_W-1:0] out,
    output logic              out_en,
    output logic              ready,
    output logic              done,
    output logic              err
);

    localparam logic [CNT_W-1:0] WS_LOAD = CNT_W'(WAIT_STATES);

    state_t              state;
    // Bus bits above ADDR_W alias away, so only the index bits are kept.
    logic [ADDR_W-1:0]   mar;
    logic [WORD_W-1:0]   wdata;
    logic [WORD_W-1:0]   ram_rdata;
    logic [CNT_W-1:0]    cnt;
    logic                is_rd;
    logic                err_q;
    logic                we;
    logic [2:0]          strb;

    assign strb = {mem_addr_en, mem_in_en, mem_out_en};

    // Write lands only on the final wait cycle while the requester still owns it.
    assign we = (state == ST_WR) && (cnt == '0) && mem_in_en;

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (WORD_W)
    ) u_mem_array (
        .clk   (clk),
        .we    (we),
        .addr  (mar),
        .wdata (wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            mar   <= '0;
            wdata <= '0;
            cnt   <= '0;
            is_rd <= 1'b0;
            err_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (multi_hot(strb)) begin
                        err_q <= 1'b1;
                    end else if (mem_addr_en) begin
                        mar <= bus_in[ADDR_W-1:0];
                    end else if (mem_in_en) begin
                        wdata <= bus_in;
                        cnt   <= WS_LOAD;
                        is_rd <= 1'b0;
                        state <= ST_WR;
                    end else if (mem_out_en) begin
                        cnt   <= WS_LOAD;
                        is_rd <= 1'b1;
                        state <= ST_RD;
                    end
                end
                ST_RD: begin
                    if (!mem_out_en) begin
                        err_q <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        if (mem_addr_en || mem_in_en)
                            err_q <= 1'b1;
                        if (cnt == '0)
                            state <= ST_DONE;
                        else
                            cnt <= cnt - 1'b1;
                    end
                end
                ST_WR: begin
                    if (!mem_in_en) begin
                        err_q <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        if (mem_addr_en || mem_out_en)
                            err_q <= 1'b1;
                        if (cnt == '0)
                            state <= ST_DONE;
                        else
                            cnt <= cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready  = (state == ST_IDLE);
    assign done   = (state == ST_DONE);
    assign out_en = (state == ST_DONE) && is_rd;
    assign out    = out_en ? ram_rdata : '0;
    assign err    = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder; three instances cover WAIT_STATES 0, 1, 2
// (instance index equals its wait-state count).
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bus_in;
    logic        addr_en, in_en, rd_en;
    int          sel;

    logic [15:0] out_w  [3];
    logic        oe_w   [3];
    logic        rdy_w  [3];
    logic        done_w [3];
    logic        err_w  [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(8), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst), .bus_in(bus_in),
        .mem_addr_en(addr_en && sel == 0), .mem_in_en(in_en && sel == 0),
        .mem_out_en(rd_en && sel == 0),
        .out(out_w[0]), .out_en(oe_w[0]), .ready(rdy_w[0]), .done(done_w[0]), .err(err_w[0]));

    mem_responder #(.ADDR_W(8), .WAIT_STATES(1)) u_dut1 (
        .clk(clk), .rst(rst), .bus_in(bus_in),
        .mem_addr_en(addr_en && sel == 1), .mem_in_en(in_en && sel == 1),
        .mem_out_en(rd_en && sel == 1),
        .out(out_w[1]), .out_en(oe_w[1]), .ready(rdy_w[1]), .done(done_w[1]), .err(err_w[1]));

    mem_responder #(.ADDR_W(8), .WAIT_STATES(2)) u_dut2 (
        .clk(clk), .rst(rst), .bus_in(bus_in),
        .mem_addr_en(addr_en && sel == 2), .mem_in_en(in_en && sel == 2),
        .mem_out_en(rd_en && sel == 2),
        .out(out_w[2]), .out_en(oe_w[2]), .ready(rdy_w[2]), .done(done_w[2]), .err(err_w[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic latch(input logic [15:0] a);
        addr_en = 1'b1;
        bus_in  = a;
        step();
        addr_en = 1'b0;
        chk("latch_ready", 32'(rdy_w[sel]), 32'd1);
        chk("latch_done", 32'(done_w[sel]), 32'd0);
    endtask

    task automatic xfer(input bit wr, input logic [15:0] d, input logic [15:0] exp, input string tag);
        int busy = 0;
        int k = 0;
        int oe_cnt = 0;
        int stray = 0;
        bit got_done = 1'b0;
        logic [15:0] rd = '0;
        bus_in = d;
        if (wr) in_en = 1'b1;
        else    rd_en = 1'b1;
        while (!got_done && k < 20) begin
            step();
            k++;
            if (done_w[sel]) got_done = 1'b1;
            else if (!rdy_w[sel]) busy++;
            if (oe_w[sel]) begin
                oe_cnt++;
                rd = out_w[sel];
            end else if (out_w[sel] != 16'h0) begin
                stray++;
            end
        end
        in_en = 1'b0;
        rd_en = 1'b0;
        chk({tag, "_done"}, 32'(got_done), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'(sel + 1));
        chk({tag, "_lat"}, 32'(k), 32'(sel + 2));
        step();
        chk({tag, "_idle_ready"}, 32'(rdy_w[sel]), 32'd1);
        chk({tag, "_idle_done"}, 32'(done_w[sel]), 32'd0);
        chk({tag, "_idle_oe"}, 32'(oe_w[sel]), 32'd0);
        chk({tag, "_idle_out"}, 32'(out_w[sel]), 32'd0);
        if (wr) begin
            chk({tag, "_wr_oe"}, 32'(oe_cnt), 32'd0);
        end else begin
            chk({tag, "_oe_cnt"}, 32'(oe_cnt), 32'd1);
            chk({tag, "_data"}, 32'(rd), 32'(exp));
            chk({tag, "_stray"}, 32'(stray), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; bus_in = '0; addr_en = 1'b0; in_en = 1'b0; rd_en = 1'b0; sel = 1;
        repeat (3) step();
        rst = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            chk("rst_ready", 32'(rdy_w[i]), 32'd1);
            chk("rst_done", 32'(done_w[i]), 32'd0);
            chk("rst_oe", 32'(oe_w[i]), 32'd0);
            chk("rst_out", 32'(out_w[i]), 32'd0);
            chk("rst_err", 32'(err_w[i]), 32'd0);
        end

        // WAIT_STATES=1: write then read
        sel = 1;
        latch(16'h0012);
        xfer(1'b1, 16'hBEEF, 16'h0, "wr1");
        xfer(1'b0, 16'h0, 16'hBEEF, "rd1");

        // aliasing: 0x0105 and 0x0005 share a word
        latch(16'h0105);
        xfer(1'b1, 16'hA5A5, 16'h0, "wr_alias");
        latch(16'h0005);
        xfer(1'b0, 16'h0, 16'hA5A5, "rd_alias");

        // conflicting strobes in IDLE
        latch(16'h0012);
        in_en = 1'b1; rd_en = 1'b1; bus_in = 16'h5555;
        step();
        chk("conf_err", 32'(err_w[1]), 32'd1);
        chk("conf_ready", 32'(rdy_w[1]), 32'd1);
        chk("conf_done", 32'(done_w[1]), 32'd0);
        in_en = 1'b0; rd_en = 1'b0;
        step();
        chk("conf_err_clear", 32'(err_w[1]), 32'd0);
        chk("conf_done2", 32'(done_w[1]), 32'd0);
        addr_en = 1'b1; rd_en = 1'b1; bus_in = 16'h0005;
        step();
        chk("conf2_err", 32'(err_w[1]), 32'd1);
        addr_en = 1'b0; rd_en = 1'b0;
        step();
        xfer(1'b0, 16'h0, 16'hBEEF, "rd_after_conf");

        // WAIT_STATES=0
        sel = 0;
        latch(16'h0040);
        xfer(1'b1, 16'h1234, 16'h0, "wr0");
        xfer(1'b0, 16'h0, 16'h1234, "rd0");

        // WAIT_STATES=2: aborted write
        sel = 2;
        latch(16'h0030);
        xfer(1'b1, 16'h0001, 16'h0, "wr2");
        in_en = 1'b1; bus_in = 16'hFFFF;
        step();
        chk("abort_busy", 32'(rdy_w[2]), 32'd0);
        in_en = 1'b0;
        step();
        chk("abort_err", 32'(err_w[2]), 32'd1);
        chk("abort_ready", 32'(rdy_w[2]), 32'd1);
        chk("abort_done", 32'(done_w[2]), 32'd0);
        step();
        chk("abort_err_clear", 32'(err_w[2]), 32'd0);
        xfer(1'b0, 16'h0, 16'h0001, "rd_abort");

        // non-owning strobe during a write
        latch(16'h0031);
        in_en = 1'b1; bus_in = 16'h0002;
        step();
        rd_en = 1'b1;
        step();
        chk("nonown_err", 32'(err_w[2]), 32'd1);
        chk("nonown_busy", 32'(rdy_w[2]), 32'd0);
        rd_en = 1'b0;
        step();
        chk("nonown_err_clear", 32'(err_w[2]), 32'd0);
        step();
        chk("nonown_done", 32'(done_w[2]), 32'd1);
        in_en = 1'b0;
        step();
        chk("nonown_ready", 32'(rdy_w[2]), 32'd1);
        xfer(1'b0, 16'h0, 16'h0002, "rd_nonown");

        // reset during a pending write discards it
        latch(16'h0030);
        in_en = 1'b1; bus_in = 16'h7777;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rstwr_ready", 32'(rdy_w[2]), 32'd1);
        chk("rstwr_done", 32'(done_w[2]), 32'd0);
        in_en = 1'b0;
        step();
        rst = 1'b1;
        step();
        latch(16'h0030);
        xfer(1'b0, 16'h0, 16'h0001, "rd_after_rstwr");

        // reset mid-read on WAIT_STATES=1
        sel = 1;
        latch(16'h0012);
        rd_en = 1'b1;
        step();
        chk("rstrd_busy", 32'(rdy_w[1]), 32'd0);
        rst = 1'b0;
        #1;
        chk("rstrd_out", 32'(out_w[1]), 32'd0);
        chk("rstrd_oe", 32'(oe_w[1]), 32'd0);
        chk("rstrd_done", 32'(done_w[1]), 32'd0);
        chk("rstrd_err", 32'(err_w[1]), 32'd0);
        chk("rstrd_ready", 32'(rdy_w[1]), 32'd1);
        rd_en = 1'b0;
        step();
        rst = 1'b1;
        step();
        latch(16'h0012);
        xfer(1'b0, 16'h0, 16'hBEEF, "rd_after_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
